// File: rtl/sd_data_pkg.sv
// rtl/sd_data_pkg.sv - shared types and constants for the SD DAT data path
package sd_data_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_END,
        ST_STAT_WAIT,
        ST_STAT,
        ST_BUSY
    } wr_state_e;

    localparam logic [1:0]  ERR_NONE         = 2'b00;
    localparam logic [1:0]  ERR_UNDERRUN     = 2'b01;
    localparam logic [1:0]  ERR_CRC          = 2'b10;
    localparam logic [1:0]  ERR_TIMEOUT      = 2'b11;

    localparam logic [15:0] CRC16_POLY       = 16'h1021;

    localparam logic [2:0]  TOKEN_ACCEPT     = 3'b010;
    localparam logic [2:0]  TOKEN_REJECT     = 3'b101;

    localparam int          TURNAROUND_TICKS = 2;

endpackage

// File: rtl/sd_crc16_serial.sv
// rtl/sd_crc16_serial.sv - bit-serial CRC16-CCITT, one bit per enable
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0x0000 (wins over en)
//   en         : fold bit_in into the CRC this cycle
//   bit_in     : serial data bit
//   crc        : current CRC register
module sd_crc16_serial
    import sd_data_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = bit_in ^ crc_q[15];
        if (clr) begin
            crc_d = 16'h0000;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_dat_write_serializer.sv
// rtl/sd_dat_write_serializer.sv - serialises one block onto DAT, then checks CRC status and busy
//
// Ports:
//   iClock, iReset    : clock, asynchronous active-low reset
//   iSD_tick          : one-cycle strobe per SD clock; line activity advances only on it
//   iStart            : request one block write (IDLE only)
//   iTimeout_val      : tick budget for the status token and for busy release (0 = off)
//   iData_from_FIFO   : FIFO word, valid the cycle after oRead_enable
//   iFIFO_empty       : FIFO empty flag
//   iData_pin         : sampled DAT line
//   oRead_enable      : one-cycle FIFO pop
//   oData_pin/oData_oe: DAT output value and drive enable
//   oBusy             : not IDLE
//   oDone/oError      : one-cycle completion / failure pulses, oErr_code valid with oError
module sd_dat_write_serializer
    import sd_data_pkg::*;
#(
    parameter int BLOCK_WORDS = 128,
    parameter int TIMEOUT_W   = 16
)
(
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iSD_tick,
    input  logic                 iStart,
    input  logic [TIMEOUT_W-1:0] iTimeout_val,
    input  logic [31:0]          iData_from_FIFO,
    input  logic                 iFIFO_empty,
    input  logic                 iData_pin,
    output logic                 oRead_enable,
    output logic                 oData_pin,
    output logic                 oData_oe,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oError,
    output logic [1:0]           oErr_code
);

    localparam int              WORD_W    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int              BIT_W     = $clog2(32);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

    wr_state_e            state_q, state_d;
    logic [31:0]          shift_q, shift_d;
    logic [31:0]          hold_q, hold_d;
    logic                 load_q, load_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [1:0]           ta_q, ta_d;
    logic [1:0]           tok_q, tok_d;
    logic [TIMEOUT_W-1:0] tout_q, tout_d;
    logic                 tout_en_q, tout_en_d;

    logic                 crc_clr, crc_en;
    logic [15:0]          crc;
    logic [3:0]           crc_idx;
    logic [TIMEOUT_W-1:0] tout_dec;
    logic                 tout_expire;
    logic [2:0]           token;
    logic                 rd_en, done, err;
    logic [1:0]           err_code;

    sd_crc16_serial u_crc (
        .clk    (iClock),
        .rst_n  (iReset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (shift_q[31]),
        .crc    (crc)
    );

    assign tout_dec    = tout_q - 1'b1;
    assign tout_expire = tout_en_q && (tout_dec == '0);
    assign token       = {tok_q, iData_pin};
    assign crc_idx     = 4'd15 - bit_q[3:0];

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        hold_d    = load_q ? iData_from_FIFO : hold_q;
        word_d    = word_q;
        bit_d     = bit_q;
        ta_d      = ta_q;
        tok_d     = tok_q;
        tout_d    = tout_q;
        tout_en_d = tout_en_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        rd_en     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        err_code  = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    if (iFIFO_empty) begin
                        err      = 1'b1;
                        err_code = ERR_UNDERRUN;
                    end else begin
                        rd_en   = 1'b1;
                        crc_clr = 1'b1;
                        word_d  = '0;
                        bit_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // The first FETCH cycle always carries the popped word.
                if (load_q) shift_d = iData_from_FIFO;
                if (iSD_tick) state_d = ST_START;
            end
            ST_START: begin
                if (iSD_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (iSD_tick) begin
                    crc_en = 1'b1;
                    // Prefetch the next word while its predecessor's MSB is on the line.
                    if (bit_q == '0 && word_q != LAST_WORD) begin
                        if (iFIFO_empty) begin
                            err      = 1'b1;
                            err_code = ERR_UNDERRUN;
                            state_d  = ST_IDLE;
                        end else begin
                            rd_en = 1'b1;
                        end
                    end
                    if (bit_q == BIT_W'(31)) begin
                        bit_d = '0;
                        if (word_q == LAST_WORD) begin
                            state_d = ST_CRC;
                        end else begin
                            shift_d = hold_q;
                            word_d  = word_q + 1'b1;
                        end
                    end else begin
                        shift_d = {shift_q[30:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                    end
                    if (err) state_d = ST_IDLE;
                end
            end
            ST_CRC: begin
                if (iSD_tick) begin
                    if (bit_q == BIT_W'(15)) begin
                        bit_d   = '0;
                        state_d = ST_END;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_END: begin
                if (iSD_tick) begin
                    ta_d      = 2'(TURNAROUND_TICKS);
                    tout_d    = iTimeout_val;
                    tout_en_d = (iTimeout_val != '0);
                    state_d   = ST_STAT_WAIT;
                end
            end
            ST_STAT_WAIT: begin
                if (iSD_tick) begin
                    tout_d = tout_dec;
                    if (ta_q != 2'd0) ta_d = ta_q - 2'd1;
                    if (ta_q == 2'd0 && !iData_pin) begin
                        bit_d   = '0;
                        state_d = ST_STAT;
                    end else if (tout_expire) begin
                        err      = 1'b1;
                        err_code = ERR_TIMEOUT;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_STAT: begin
                if (iSD_tick) begin
                    tok_d = {tok_q[0], iData_pin};
                    if (bit_q == BIT_W'(2)) begin
                        bit_d = '0;
                        if (token == TOKEN_ACCEPT) begin
                            tout_d    = iTimeout_val;
                            tout_en_d = (iTimeout_val != '0);
                            state_d   = ST_BUSY;
                        end else begin
                            err      = 1'b1;
                            err_code = ERR_CRC;
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (iSD_tick) begin
                    tout_d = tout_dec;
                    if (iData_pin) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else if (tout_expire) begin
                        err      = 1'b1;
                        err_code = ERR_TIMEOUT;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        load_d = rd_en;
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            hold_q    <= '0;
            load_q    <= 1'b0;
            word_q    <= '0;
            bit_q     <= '0;
            ta_q      <= '0;
            tok_q     <= '0;
            tout_q    <= '0;
            tout_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            load_q    <= load_d;
            word_q    <= word_d;
            bit_q     <= bit_d;
            ta_q      <= ta_d;
            tok_q     <= tok_d;
            tout_q    <= tout_d;
            tout_en_q <= tout_en_d;
        end
    end

    always_comb begin
        oData_pin = 1'b1;
        case (state_q)
            ST_START: oData_pin = 1'b0;
            ST_DATA:  oData_pin = shift_q[31];
            ST_CRC:   oData_pin = crc[crc_idx];
            default:  oData_pin = 1'b1;
        endcase
    end

    assign oData_oe     = (state_q == ST_START) || (state_q == ST_DATA) ||
                          (state_q == ST_CRC)   || (state_q == ST_END);
    assign oBusy        = (state_q != ST_IDLE);
    assign oRead_enable = rd_en;
    assign oDone        = done;
    assign oError       = err;
    assign oErr_code    = err_code;

endmodule

// File: tb/tb_sd_dat_write_serializer.sv
// tb/tb_sd_dat_write_serializer.sv - self-checking bench for sd_dat_write_serializer
module tb_sd_dat_write_serializer;

    localparam int BW     = 128;
    localparam int TW     = 16;
    localparam int NBITS  = BW * 32;
    localparam int FRAME  = NBITS + 18;

    logic          iClock = 1'b0;
    logic          iReset = 1'b0;
    logic          iSD_tick = 1'b0;
    logic          iStart = 1'b0;
    logic [TW-1:0] iTimeout_val = '0;
    logic [31:0]   iData_from_FIFO = '0;
    logic          iFIFO_empty = 1'b1;
    logic          iData_pin = 1'b1;
    logic          oRead_enable, oData_pin, oData_oe, oBusy, oDone, oError;
    logic [1:0]    oErr_code;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fifo_q[$];
    logic        cap[$];
    logic        expq[$];
    logic [31:0] words[BW];
    int          pops = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [1:0]  last_code = 2'b00;
    logic        do_pop;

    sd_dat_write_serializer #(.BLOCK_WORDS(BW), .TIMEOUT_W(TW)) dut (
        .iClock          (iClock),
        .iReset          (iReset),
        .iSD_tick        (iSD_tick),
        .iStart          (iStart),
        .iTimeout_val    (iTimeout_val),
        .iData_from_FIFO (iData_from_FIFO),
        .iFIFO_empty     (iFIFO_empty),
        .iData_pin       (iData_pin),
        .oRead_enable    (oRead_enable),
        .oData_pin       (oData_pin),
        .oData_oe        (oData_oe),
        .oBusy           (oBusy),
        .oDone           (oDone),
        .oError          (oError),
        .oErr_code       (oErr_code)
    );

    always #5 iClock = ~iClock;

    // SD tick: one cycle high, period of 2 or 3 system clocks
    initial begin
        forever begin
            repeat ($urandom_range(1, 2)) @(posedge iClock);
            #1 iSD_tick = 1'b1;
            @(posedge iClock);
            #1 iSD_tick = 1'b0;
        end
    end

    // FIFO model, line capture and pulse counters
    initial begin
        forever begin
            @(negedge iClock);
            do_pop = oRead_enable;
            if (oRead_enable) pops++;
            if (oDone) done_cnt++;
            if (oError) begin
                err_cnt++;
                last_code = oErr_code;
            end
            if (oDone && oError) both_cnt++;
            if (iSD_tick && oData_oe) cap.push_back(oData_pin);
            @(posedge iClock);
            #1;
            if (do_pop && fifo_q.size() > 0) iData_from_FIFO = fifo_q.pop_front();
            iFIFO_empty = (fifo_q.size() == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of (message * x^16) divided by x^16+x^12+x^5+1
    function automatic logic [15:0] model_crc();
        int r = 0;
        int b;
        for (int i = 0; i < NBITS + 16; i++) begin
            b = (i < NBITS) ? int'(words[i / 32][31 - (i % 32)]) : 0;
            r = (r << 1) | b;
            if ((r & 32'h0001_0000) != 0) r = r ^ 32'h0001_1021;
        end
        return r[15:0];
    endfunction

    task automatic build_expected();
        logic [15:0] c;
        c = model_crc();
        expq.delete();
        expq.push_back(1'b0);
        for (int w = 0; w < BW; w++)
            for (int b = 31; b >= 0; b--) expq.push_back(words[w][b]);
        for (int i = 15; i >= 0; i--) expq.push_back(c[i]);
        expq.push_back(1'b1);
    endtask

    task automatic check_frame(input string tag, input int n);
        int mism = 0;
        build_expected();
        check({tag, "_len"}, 32'(cap.size()), 32'(n));
        for (int i = 0; i < n && i < cap.size(); i++)
            if (cap[i] !== expq[i]) mism++;
        check({tag, "_bits"}, 32'(mism), 32'd0);
    endtask

    task automatic fill(input int n, input bit ones);
        fifo_q.delete();
        for (int i = 0; i < BW; i++) begin
            words[i] = ones ? 32'hFFFF_FFFF : $urandom();
            if (i < n) fifo_q.push_back(words[i]);
        end
        repeat (2) @(posedge iClock);
    endtask

    task automatic start_block();
        cap.delete();
        pops = 0;
        @(posedge iClock);
        #1 iStart = 1'b1;
        @(posedge iClock);
        #1 iStart = 1'b0;
    endtask

    task automatic wait_frame_end(input string tag);
        int n = 0;
        while (oData_oe !== 1'b1 && n < 100) begin
            @(negedge iClock);
            n++;
        end
        n = 0;
        while (oData_oe !== 1'b0 && n < 20000) begin
            @(negedge iClock);
            n++;
        end
        check({tag, "_frame_done"}, {31'd0, oData_oe}, 32'd0);
    endtask

    task automatic wait_tick();
        do @(negedge iClock); while (!iSD_tick);
        @(posedge iClock);
        #2;
    endtask

    task automatic card_drive(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            iData_pin = bits[i];
            wait_tick();
        end
    endtask

    task automatic card_accept(input string tag, input int busy_len);
        int d0;
        int e0;
        card_drive(16'b110010, 6);
        d0 = done_cnt;
        e0 = err_cnt;
        iData_pin = 1'b0;
        for (int i = 0; i < busy_len; i++) wait_tick();
        check({tag, "_no_early_done"}, 32'(done_cnt - d0), 32'd0);
        iData_pin = 1'b1;
        wait_tick();
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_no_err"}, 32'(err_cnt - e0), 32'd0);
        check({tag, "_pops"}, 32'(pops), 32'(BW));
        @(negedge iClock);
        check({tag, "_idle"}, {31'd0, oBusy}, 32'd0);
    endtask

    task automatic ticks_to_error(input logic level, output int k);
        int e0 = err_cnt;
        k = -1;
        iData_pin = level;
        for (int i = 1; i <= 60; i++) begin
            wait_tick();
            if (err_cnt != e0) begin
                k = i;
                break;
            end
        end
        iData_pin = 1'b1;
    endtask

    initial begin
        int          k;
        int          n;
        int          e0;
        int          d0;
        logic [15:0] crc_obs;

        // Reset state
        repeat (3) @(posedge iClock);
        #1;
        check("rst_pin", {31'd0, oData_pin}, 32'd1);
        check("rst_oe", {31'd0, oData_oe}, 32'd0);
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        check("rst_rd", {31'd0, oRead_enable}, 32'd0);
        check("rst_done_err", {30'd0, oDone, oError}, 32'd0);
        check("rst_code", {30'd0, oErr_code}, 32'd0);
        @(negedge iClock);
        iReset = 1'b1;
        repeat (2) @(posedge iClock);
        #1;

        // Start with an empty FIFO
        e0 = err_cnt;
        iStart = 1'b1;
        @(negedge iClock);
        check("empty_err", {31'd0, oError}, 32'd1);
        check("empty_code", {30'd0, oErr_code}, 32'd1);
        check("empty_rd", {31'd0, oRead_enable}, 32'd0);
        @(posedge iClock);
        #1 iStart = 1'b0;
        @(negedge iClock);
        check("empty_idle", {31'd0, oBusy}, 32'd0);
        check("empty_one_pulse", 32'(err_cnt - e0), 32'd1);

        // All-ones block, timeout disabled, stray iStart mid-frame
        iTimeout_val = '0;
        fill(BW, 1'b1);
        start_block();
        repeat (200) @(posedge iClock);
        check("ones_busy", {31'd0, oBusy}, 32'd1);
        #1 iStart = 1'b1;
        @(posedge iClock);
        #1 iStart = 1'b0;
        wait_frame_end("ones");
        check_frame("ones", FRAME);
        crc_obs = '0;
        for (int i = 0; i < 16; i++) crc_obs = {crc_obs[14:0], cap[NBITS + 1 + i]};
        check("ones_crc", {16'd0, crc_obs}, 32'h7FA1);
        card_accept("ones", 10);

        // Random block, random busy length
        iTimeout_val = TW'(1000);
        fill(BW, 1'b0);
        start_block();
        wait_frame_end("rand");
        check_frame("rand", FRAME);
        card_accept("rand", $urandom_range(1, 15));

        // CRC rejected by the card
        fill(BW, 1'b0);
        start_block();
        wait_frame_end("rej");
        check_frame("rej", FRAME);
        e0 = err_cnt;
        d0 = done_cnt;
        card_drive(16'b110101, 6);
        check("rej_err", 32'(err_cnt - e0), 32'd1);
        check("rej_code", {30'd0, last_code}, 32'd2);
        check("rej_no_done", 32'(done_cnt - d0), 32'd0);

        // Status token never arrives
        iTimeout_val = TW'(20);
        fill(BW, 1'b0);
        start_block();
        wait_frame_end("stto");
        ticks_to_error(1'b1, k);
        check("stto_tick", 32'(k), 32'd20);
        check("stto_code", {30'd0, last_code}, 32'd3);

        // Card never releases busy
        fill(BW, 1'b0);
        start_block();
        wait_frame_end("bsto");
        d0 = done_cnt;
        card_drive(16'b110010, 6);
        ticks_to_error(1'b0, k);
        check("bsto_tick", 32'(k), 32'd20);
        check("bsto_code", {30'd0, last_code}, 32'd3);
        check("bsto_no_done", 32'(done_cnt - d0), 32'd0);

        // Underrun after three words
        iTimeout_val = TW'(1000);
        fill(3, 1'b0);
        e0 = err_cnt;
        start_block();
        n = 0;
        while (oError !== 1'b1 && n < 2000) begin
            @(negedge iClock);
            n++;
        end
        check("unr_seen", {31'd0, oError}, 32'd1);
        check("unr_code_now", {30'd0, oErr_code}, 32'd1);
        @(negedge iClock);
        check("unr_oe", {31'd0, oData_oe}, 32'd0);
        check("unr_idle", {31'd0, oBusy}, 32'd0);
        check("unr_err", 32'(err_cnt - e0), 32'd1);
        check("unr_pops", 32'(pops), 32'd3);
        check_frame("unr", 66);

        // Reset mid-DATA, then a clean restart
        fill(BW, 1'b0);
        start_block();
        n = 0;
        while (cap.size() < 501 && n < 5000) begin
            @(negedge iClock);
            n++;
        end
        check("mid_reached", 32'(cap.size() >= 501), 32'd1);
        @(posedge iClock);
        #2 iReset = 1'b0;
        #1;
        check("mid_oe", {31'd0, oData_oe}, 32'd0);
        check("mid_pin", {31'd0, oData_pin}, 32'd1);
        check("mid_busy", {31'd0, oBusy}, 32'd0);
        check("mid_rd", {31'd0, oRead_enable}, 32'd0);
        repeat (3) @(negedge iClock);
        iReset = 1'b1;
        fill(BW, 1'b0);
        start_block();
        wait_frame_end("rst2");
        check_frame("rst2", FRAME);
        card_accept("rst2", 4);

        check("never_both", 32'(both_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
